alu_exec_unit: RTL and testbench

Handshaked execution unit that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a registered result plus branch/zero flag. It sits in the EX stage between operand muxing and the EX/MEM register. Shifts run iteratively, one bit per cycle, and back-pressure the pipeline; all other operations complete in one cycle.

---
 rtl/alu_exec_pkg.sv | 37 +++
 rtl/alu_exec_if.sv | 33 +++
 rtl/alu_shift_iter.sv | 69 ++++++
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types and constants for the EX-stage execution unit.
//   alu_op_e           : 4-bit operation codes from the ALU controller
//   exec_state_e       : control FSM states (IDLE, SHIFT)
//   DEFAULT_DATA_WIDTH : default operand/result width
// Optional build macro: ALU_FAST_SHIFT_EN (single-cycle barrel shifter).
package alu_exec_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_XOR = 4'b0001,
    OP_ADD = 4'b0010,
    OP_BNE = 4'b0100,
    OP_OR  = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_LUI = 4'b1001,
    OP_SUB = 4'b1010,
    OP_SLT = 4'b1100,
    OP_BLT = 4'b1101,
    OP_SRL = 4'b1110,
    OP_BGE = 4'b1111
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_e;

  // True for the three shift operations.
  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: handshake bundle between operand muxing and the execution unit.
//   in_valid/in_ready   : operation request handshake
//   Operation/SrcA/SrcB : op code and operands (SrcB low bits carry shamt)
//   out_valid/out_ready : result handshake
//   ALUResult/zero      : registered result and branch/zero flag
//   busy                : unit is iterating a shift
// master = producer side (pipeline), slave = the execution unit.
interface alu_exec_if #(
  parameter int unsigned DATA_WIDTH = alu_exec_pkg::DEFAULT_DATA_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  zero;
  logic                  busy;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, zero, busy
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, zero, busy
  );

endinterface

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle shifter datapath.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : capture a_i / shamt_i / op_i
//   step_i     : advance one bit while the count is non-zero
//   next_c     : accumulator shifted by one bit (combinational)
//   done_c     : this step is the last one; next_c is the final value
// Not instantiated when ALU_FAST_SHIFT_EN is defined.
module alu_shift_iter #(
  parameter int unsigned DATA_WIDTH = alu_exec_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_i,
  input  logic                          step_i,
  input  alu_exec_pkg::alu_op_e         op_i,
  input  logic [DATA_WIDTH-1:0]         a_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]         next_c,
  output logic                          done_c
);
  import alu_exec_pkg::*;

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  alu_op_e               op_q, op_d;

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= OP_SLL;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  // Single-bit shift of the accumulator; SRA replicates the sign bit.
  always_comb begin
    next_c = {acc_q[DATA_WIDTH-2:0], 1'b0};
    case (op_q)
      OP_SRA:  next_c = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      OP_SRL:  next_c = {1'b0, acc_q[DATA_WIDTH-1:1]};
      default: next_c = {acc_q[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  assign done_c = step_i && (cnt_q == SHW'(1));

  // Load or step the accumulator and remaining count.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (load_i) begin
      acc_d = a_i;
      cnt_d = shamt_i;
      op_d  = op_i;
    end else if (step_i && (cnt_q != '0)) begin
      acc_d = next_c;
      cnt_d = cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked EX-stage ALU with registered result and zero flag.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : alu_exec_if.slave (in_valid/in_ready, Operation, SrcA, SrcB,
//           out_valid/out_ready, ALUResult, zero, busy)
// Shifts with non-zero shamt iterate one bit per cycle in SHIFT and stall
// the input; every other op completes in one cycle.
// Build macro ALU_FAST_SHIFT_EN: barrel shifter, no SHIFT state, busy tied 0.
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH = alu_exec_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  alu_exec_if.slave bus
);
  import alu_exec_pkg::*;

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  exec_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  alu_op_e               op_c;
  logic [SHW-1:0]        shamt_c;
  logic [DATA_WIDTH-1:0] alu_res_c;
  logic                  alu_zero_c;
  logic                  iter_shift_c;
  logic                  in_ready_c;
  logic                  load_c;

  assign op_c    = alu_op_e'(bus.Operation);
  assign shamt_c = bus.SrcB[SHW-1:0];

  // Single-cycle result and flag for the op presented on the bus.
  always_comb begin
    logic [DATA_WIDTH-1:0] diff;
    logic                  lt;
    diff      = bus.SrcA - bus.SrcB;
    lt        = $signed(bus.SrcA) < $signed(bus.SrcB);
    alu_res_c = '0;
    case (op_c)
      OP_AND: alu_res_c = bus.SrcA & bus.SrcB;
      OP_XOR: alu_res_c = bus.SrcA ^ bus.SrcB;
      OP_OR:  alu_res_c = bus.SrcA | bus.SrcB;
      OP_ADD: alu_res_c = bus.SrcA + bus.SrcB;
      OP_LUI: alu_res_c = bus.SrcB;
      OP_SLT: alu_res_c = DATA_WIDTH'(lt);
      OP_SUB, OP_BEQ, OP_BNE, OP_BLT, OP_BGE: alu_res_c = diff;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_res_c = bus.SrcA << shamt_c;
      OP_SRL: alu_res_c = bus.SrcA >> shamt_c;
      OP_SRA: alu_res_c = DATA_WIDTH'($signed(bus.SrcA) >>> shamt_c);
`else
      // Only reached here with shamt 0; non-zero shamts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: alu_res_c = bus.SrcA;
`endif
      default: alu_res_c = '0;
    endcase

    case (op_c)
      OP_BEQ:  alu_zero_c = (diff == '0);
      OP_BNE:  alu_zero_c = (diff != '0);
      OP_BLT:  alu_zero_c = lt;
      OP_BGE:  alu_zero_c = !lt;
      default: alu_zero_c = (alu_res_c == '0);
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign iter_shift_c = 1'b0;
`else
  logic [DATA_WIDTH-1:0] shift_next_c;
  logic                  shift_done_c;
  logic                  step_c;

  assign iter_shift_c = is_shift_op(op_c) && (shamt_c != '0);
  assign step_c       = (state_q == SHIFT);

  alu_shift_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_c),
    .step_i  (step_c),
    .op_i    (op_c),
    .a_i     (bus.SrcA),
    .shamt_i (shamt_c),
    .next_c  (shift_next_c),
    .done_c  (shift_done_c)
  );
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and handshake logic; an untaken result holds everything.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    load_c      = 1'b0;
    in_ready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = !out_valid_q || bus.out_ready;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        if (bus.in_valid && in_ready_c) begin
          if (iter_shift_c) begin
            load_c  = 1'b1;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            result_d    = alu_res_c;
            zero_d      = alu_zero_c;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
        if (shift_done_c) begin
          result_d    = shift_next_c;
          zero_d      = (shift_next_c == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result_q;
  assign bus.zero      = zero_q;
`ifdef ALU_FAST_SHIFT_EN
  assign bus.busy      = 1'b0;
`else
  assign bus.busy      = busy_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against
// an arithmetic reference model of the op table, latency and handshake.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_exec_if #(.DATA_WIDTH(DW)) bus ();

  alu_exec_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: result of op on (a, b).
  function automatic logic [31:0] m_res(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a ^ b;
      4'b0010: return a + b;
      4'b0101: return a | b;
      4'b0110: return a << sh;
      4'b0111: return 32'(sa >>> sh);
      4'b1110: return a >> sh;
      4'b1001: return b;
      4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010, 4'b1000, 4'b0100, 4'b1101, 4'b1111: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_zero(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    case (op)
      4'b1000: return a == b;
      4'b0100: return a != b;
      4'b1101: return $signed(a) < $signed(b);
      4'b1111: return $signed(a) >= $signed(b);
      default: return m_res(op, a, b) == 32'd0;
    endcase
  endfunction

  // Edges from the accept edge (inclusive) until out_valid is visible.
  function automatic int m_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'b0110 || op == 4'b0111 || op == 4'b1110) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Present one op, wait for its result, check it, optionally stall the take.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    logic [31:0] er;
    logic        ez;
    int          lat;
    int          cyc;
    er  = m_res(op, a, b);
    ez  = m_zero(op, a, b);
    lat = m_lat(op, b);
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.out_ready = 1'b1;
    #1;
    chk1("in_ready_at_issue", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.Operation = 4'($urandom);
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      chk1("busy_in_shift", bus.busy, 1'b1);
      chk1("in_ready_in_shift", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      cyc++;
    end
    chk32("latency", 32'(cyc), 32'(lat));
    chk1("out_valid", bus.out_valid, 1'b1);
    chk32($sformatf("result op=%b a=%h b=%h", op, a, b), bus.ALUResult, er);
    chk1($sformatf("zero op=%b a=%h b=%h", op, a, b), bus.zero, ez);
    chk1("busy_after", bus.busy, 1'b0);
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      #1;
      chk1("in_ready_stalled", bus.in_ready, 1'b0);
      repeat (stall) begin
        @(posedge clk); #1;
        chk1("hold_valid", bus.out_valid, 1'b1);
        chk32("hold_result", bus.ALUResult, er);
        chk1("hold_zero", bus.zero, ez);
      end
      bus.out_ready = 1'b1;
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          stall;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Operation = 4'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk32("rst_result", bus.ALUResult, 32'd0);
    chk1("rst_zero", bus.zero, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    // Add wrap into the sign bit.
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    chk32("add_ovf", bus.ALUResult, 32'h8000_0000);

    // SUB then BEQ on consecutive cycles.
    bus.in_valid  = 1'b1;
    bus.Operation = OP_SUB;
    bus.SrcA      = 32'd5;
    bus.SrcB      = 32'd5;
    @(posedge clk); #1;
    chk1("b2b_sub_valid", bus.out_valid, 1'b1);
    chk32("b2b_sub_res", bus.ALUResult, 32'd0);
    chk1("b2b_sub_zero", bus.zero, 1'b1);
    bus.Operation = OP_BEQ;
    bus.SrcA      = 32'd3;
    bus.SrcB      = 32'd3;
    #1;
    chk1("b2b_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk1("b2b_beq_valid", bus.out_valid, 1'b1);
    chk32("b2b_beq_res", bus.ALUResult, 32'd0);
    chk1("b2b_beq_zero", bus.zero, 1'b1);

    // Shifts: arithmetic right by 4, left by 0.
    issue(OP_SRA, 32'h8000_0000, 32'd4, 0);
    chk32("sra4", bus.ALUResult, 32'hF800_0000);
    issue(OP_SLL, 32'h1234_5678, 32'd0, 0);
    chk32("sll0", bus.ALUResult, 32'h1234_5678);

    // Signed compares.
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 0);
    chk1("blt_zero", bus.zero, 1'b1);
    issue(OP_BGE, 32'hFFFF_FFFF, 32'd1, 0);
    chk1("bge_zero", bus.zero, 1'b0);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    chk32("slt_res", bus.ALUResult, 32'd1);

    // Back-pressure, then same-cycle take and accept.
    issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, 3);
    chk32("or_held", bus.ALUResult, 32'h0000_00FF);
    issue(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 0);

    // Reset during an iterative shift.
    bus.in_valid  = 1'b1;
    bus.Operation = OP_SRL;
    bus.SrcA      = 32'hFFFF_0000;
    bus.SrcB      = 32'd10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    chk1("srl_busy", bus.busy, 1'b1);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("midrst_valid", bus.out_valid, 1'b0);
    chk32("midrst_result", bus.ALUResult, 32'd0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_zero", bus.zero, 1'b0);
    reset = 1'b0;
    #1;
    chk1("midrst_in_ready", bus.in_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk1("midrst_no_result", bus.out_valid, 1'b0);
    issue(OP_ADD, 32'd2, 32'd3, 0);
    chk32("after_rst_add", bus.ALUResult, 32'd5);

    // Randomized ops, including undefined codes, equal operands and stalls.
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(op, a, b, stall);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        chk1("idle_taken", bus.out_valid, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
